// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation block: FSM states,
// key register selects and the fixed operation latency.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQR,
        MUL,
        NEXT,
        DONE
    } state_t;

    localparam logic [1:0] KEY_N = 2'd0;
    localparam logic [1:0] KEY_E = 2'd1;
    localparam logic [1:0] KEY_D = 2'd2;

    // Cycles from the accept edge to out_valid_o for a non-error operation.
    function automatic int latency(input int w, input int ew);
        return 2 + 2 * ew * (w + 1);
    endfunction

endpackage

// File: rtl/rsa_modexp_modmul.sv
// Interleaved radix-2 modular multiplier: p = a*b mod n, one bit of a per
// cycle, MSB first; done pulses W+1 cycles after start.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int CW = $clog2(W);

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   n_reg;
    logic [W+1:0]   acc_reg;
    logic [CW-1:0]  cnt_reg;
    logic           run_reg;
    logic           done_reg;

    logic [W+1:0]   n_ext;
    logic [W+1:0]   dbl;
    logic [W+1:0]   dbl_red;
    logic [W+1:0]   sum;
    logic [W+1:0]   acc_next;

    // Both reductions keep acc below n, so 2*acc and acc+b stay under 2n.
    always_comb begin
        n_ext    = {2'b00, n_reg};
        dbl      = acc_reg << 1;
        dbl_red  = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        sum      = dbl_red + (a_reg[W-1] ? {2'b00, b_reg} : '0);
        acc_next = (sum >= n_ext) ? (sum - n_ext) : sum;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            n_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                a_reg   <= a;
                b_reg   <= b;
                n_reg   <= n;
                acc_reg <= '0;
                cnt_reg <= CW'(W - 1);
                run_reg <= 1'b1;
            end else if (run_reg) begin
                acc_reg <= acc_next;
                a_reg   <= a_reg << 1;
                if (cnt_reg == '0) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign p    = acc_reg[W-1:0];

endmodule

// File: rtl/rsa_modexp.sv
// RSA modular exponentiation m^exp mod n, MSB-first square-and-always-multiply
// with a single shared modular multiplier and valid/ready handshakes.
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int W  = 64,
    parameter int EW = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_we_i,
    input  logic [1:0]   key_sel_i,
    input  logic [W-1:0] key_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_mode_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    key_reg [3];
    logic [2:0]      key_wr;

    logic [W-1:0]    n_run_reg;
    logic [W-1:0]    m_run_reg;
    logic [EW-1:0]   exp_run_reg;
    logic [W-1:0]    r_reg;
    logic [IW-1:0]   bit_idx_reg;
    logic            out_valid_reg;
    logic [W-1:0]    out_data_reg;
    logic            err_reg;

    logic            accept;
    logic            check_err;
    logic            exp_bit;
    logic [W-1:0]    one_mod_n;
    logic [W-1:0]    r_step;
    logic [EW-1:0]   exp_sel;

    logic            mul_start;
    logic            mul_done;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [W-1:0]    mul_n;
    logic [W-1:0]    mul_p;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key_wr
            assign key_wr[gi] = key_we_i && (state_reg == IDLE) && (key_sel_i == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                key_reg[i] <= '0;
            end else if (key_wr[i]) begin
                key_reg[i] <= key_data_i;
            end
        end
    end

    assign accept    = in_valid_i && (state_reg == IDLE);
    assign check_err = (n_run_reg == '0) || (m_run_reg >= n_run_reg);
    assign one_mod_n = (key_reg[KEY_N] == W'(1)) ? '0 : W'(1);
    assign exp_bit   = exp_run_reg[bit_idx_reg];
    assign r_step    = exp_bit ? mul_p : r_reg;
    assign exp_sel   = in_mode_i ? key_reg[KEY_D][EW-1:0] : key_reg[KEY_E][EW-1:0];
    assign mul_n     = (state_reg == IDLE) ? key_reg[KEY_N] : n_run_reg;

    // Each multiply is launched in the cycle before its state is entered, so
    // the first square overlaps CHECK and each later square overlaps NEXT.
    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        mul_a      = r_reg;
        mul_b      = r_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CHECK;
                    mul_start  = 1'b1;
                    mul_a      = one_mod_n;
                    mul_b      = one_mod_n;
                end
            end
            CHECK: state_next = check_err ? DONE : SQR;
            SQR: begin
                if (mul_done) begin
                    state_next = MUL;
                    mul_start  = 1'b1;
                    mul_a      = mul_p;
                    mul_b      = m_run_reg;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = NEXT;
                    if (bit_idx_reg != '0) begin
                        mul_start = 1'b1;
                        mul_a     = r_step;
                        mul_b     = r_step;
                    end
                end
            end
            NEXT: state_next = (bit_idx_reg == '0) ? DONE : SQR;
            DONE: begin
                if (out_valid_reg && out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            n_run_reg     <= '0;
            m_run_reg     <= '0;
            exp_run_reg   <= '0;
            r_reg         <= '0;
            bit_idx_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        n_run_reg   <= key_reg[KEY_N];
                        m_run_reg   <= in_data_i;
                        exp_run_reg <= exp_sel;
                        r_reg       <= one_mod_n;
                        bit_idx_reg <= IW'(EW - 1);
                    end
                end
                CHECK: begin
                    if (check_err) begin
                        out_data_reg <= '0;
                        err_reg      <= 1'b1;
                    end
                end
                SQR: if (mul_done) r_reg <= mul_p;
                MUL: if (mul_done) r_reg <= r_step;
                NEXT: begin
                    if (bit_idx_reg == '0) begin
                        out_data_reg <= r_reg;
                        err_reg      <= 1'b0;
                    end else begin
                        bit_idx_reg <= bit_idx_reg - 1'b1;
                    end
                end
                DONE: begin
                    // Valid rises one cycle after DONE is entered and holds until taken.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    rsa_modmul #(
        .W(W)
    ) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .n     (mul_n),
        .done  (mul_done),
        .p     (mul_p)
    );

    assign in_ready_o  = (state_reg == IDLE);
    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign err_o       = err_reg;
    assign busy_o      = (state_reg == CHECK) || (state_reg == SQR) ||
                         (state_reg == MUL)   || (state_reg == NEXT);

endmodule
